// File: rtl/rl_scfifo_unpacker.sv
// rl_scfifo_unpacker: pops wide words from a show-ahead FIFO read port and serialises each
// word into RATIO narrow beats on a valid/ready stream. The next word is reloaded in the
// same cycle as the last-beat transfer, so there is no bubble across word boundaries.
module rl_scfifo_unpacker #(
    parameter int unsigned FIFO_DATA_SIZE = 32,
    parameter int unsigned OUT_DATA_SIZE  = 8,
    parameter string       BEAT_ORDER     = "LSB_FIRST",
    parameter int unsigned RATIO          = FIFO_DATA_SIZE / OUT_DATA_SIZE,
    parameter int unsigned BEAT_BITS      = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                      rst_ni,
    input  logic                      clk_i,
    input  logic                      clr_i,
    input  logic [FIFO_DATA_SIZE-1:0] fifo_q_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_rdena_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [OUT_DATA_SIZE-1:0]  m_data_o,
    output logic                      m_last_o,
    output logic                      busy_o
);

    if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("rl_scfifo_unpacker: RATIO must be a power of two and at least 1");
    end

    if (BEAT_ORDER != "LSB_FIRST" && BEAT_ORDER != "MSB_FIRST") begin : g_bad_order
        $error("rl_scfifo_unpacker: BEAT_ORDER must be LSB_FIRST or MSB_FIRST");
    end

    localparam bit                   MsbFirst = (BEAT_ORDER == "MSB_FIRST");
    localparam logic [BEAT_BITS-1:0] LastBeat = BEAT_BITS'(RATIO - 1);

    logic [FIFO_DATA_SIZE-1:0] hold_q, hold_d;
    logic [BEAT_BITS-1:0]      beat_q, beat_d;
    logic                      valid_q, valid_d;  // also the EMPTY(0)/HOLD(1) state bit
    logic [BEAT_BITS-1:0]      slice_idx;
    logic                      xfer, last, rdena;

    assign xfer  = valid_q & m_ready_i;
    assign last  = (beat_q == LastBeat);
    // Pop when idle, or when the last beat leaves this cycle (bubble-free reload).
    assign rdena = rst_ni & ~clr_i & ~fifo_empty_i & (~valid_q | (xfer & last));

    // Next-state: clear beats everything, then reload, then beat advance / word retire.
    always_comb begin
        hold_d  = hold_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        if (clr_i) begin
            beat_d  = '0;
            valid_d = 1'b0;
        end else if (rdena) begin
            hold_d  = fifo_q_i;
            beat_d  = '0;
            valid_d = 1'b1;
        end else if (xfer && !last) begin
            beat_d  = beat_q + 1'b1;
        end else if (xfer && last) begin
            beat_d  = '0;
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset; a partial word is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    // Beat slice select; driven from registers only, so no input reaches m_data_o.
    always_comb begin
        slice_idx = MsbFirst ? (LastBeat - beat_q) : beat_q;
        m_data_o  = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (slice_idx == BEAT_BITS'(i)) begin
                m_data_o = hold_q[i*OUT_DATA_SIZE +: OUT_DATA_SIZE];
            end
        end
    end

    assign fifo_rdena_o = rdena;
    assign m_valid_o    = valid_q;
    assign m_last_o     = valid_q & last;
    assign busy_o       = valid_q;

endmodule

// File: tb/tb_rl_scfifo_unpacker.sv
// Bench for rl_scfifo_unpacker: three instances (32->8 LSB, 32->8 MSB, 32->32), each fed by a
// small array-based show-ahead FIFO model. Instance A is also tracked by a beat scoreboard.
module tb_rl_scfifo_unpacker;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Instance A: 32->8 LSB_FIRST
    logic        a_clr, a_ready, a_rdena, a_valid, a_last, a_busy, a_empty;
    logic [7:0]  a_data;
    logic [31:0] a_q;
    logic [31:0] a_mem [0:63];
    int          a_wp = 0, a_rp = 0;
    assign a_empty = (a_wp == a_rp);
    assign a_q     = a_mem[a_rp];
    always @(posedge clk_i) if (a_rdena) a_rp <= a_rp + 1;

    rl_scfifo_unpacker #(.FIFO_DATA_SIZE(32), .OUT_DATA_SIZE(8)) u_a (
        .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(a_clr), .fifo_q_i(a_q),
        .fifo_empty_i(a_empty), .fifo_rdena_o(a_rdena), .m_valid_o(a_valid),
        .m_ready_i(a_ready), .m_data_o(a_data), .m_last_o(a_last), .busy_o(a_busy)
    );

    // Instance B: 32->8 MSB_FIRST
    logic        b_clr, b_ready, b_rdena, b_valid, b_last, b_busy, b_empty;
    logic [7:0]  b_data;
    logic [31:0] b_q;
    logic [31:0] b_mem [0:15];
    int          b_wp = 0, b_rp = 0;
    assign b_empty = (b_wp == b_rp);
    assign b_q     = b_mem[b_rp];
    always @(posedge clk_i) if (b_rdena) b_rp <= b_rp + 1;

    rl_scfifo_unpacker #(.FIFO_DATA_SIZE(32), .OUT_DATA_SIZE(8), .BEAT_ORDER("MSB_FIRST")) u_b (
        .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(b_clr), .fifo_q_i(b_q),
        .fifo_empty_i(b_empty), .fifo_rdena_o(b_rdena), .m_valid_o(b_valid),
        .m_ready_i(b_ready), .m_data_o(b_data), .m_last_o(b_last), .busy_o(b_busy)
    );

    // Instance C: 32->32, RATIO=1
    logic        c_clr, c_ready, c_rdena, c_valid, c_last, c_busy, c_empty;
    logic [31:0] c_data;
    logic [31:0] c_q;
    logic [31:0] c_mem [0:15];
    int          c_wp = 0, c_rp = 0;
    assign c_empty = (c_wp == c_rp);
    assign c_q     = c_mem[c_rp];
    always @(posedge clk_i) if (c_rdena) c_rp <= c_rp + 1;

    rl_scfifo_unpacker #(.FIFO_DATA_SIZE(32), .OUT_DATA_SIZE(32)) u_c (
        .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(c_clr), .fifo_q_i(c_q),
        .fifo_empty_i(c_empty), .fifo_rdena_o(c_rdena), .m_valid_o(c_valid),
        .m_ready_i(c_ready), .m_data_o(c_data), .m_last_o(c_last), .busy_o(c_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beat stream of instance A: every pushed word becomes four byte beats.
    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;
    beat_t exp_q[$];

    function automatic void discard_word();
        beat_t b;
        b.last = 1'b0;
        while (!b.last && exp_q.size() > 0) b = exp_q.pop_front();
    endfunction

    task automatic push_a(input logic [31:0] w);
        beat_t b;
        a_mem[a_wp] = w;
        a_wp++;
        for (int i = 0; i < 4; i++) begin
            b.d    = w[8*i +: 8];
            b.last = (i == 3);
            exp_q.push_back(b);
        end
    endtask

    // Compare process for instance A, sampled on the falling edge.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_hold = 1'b0;
        end else begin
            if (a_rdena) chk("sb_no_overread", a_empty, 0);
            chk("sb_busy", a_busy, a_valid);
            if (!a_valid) chk("sb_last_idle", a_last, 0);
            if (prev_hold) begin
                chk("sb_hold_valid", a_valid, 1);
                chk("sb_hold_data", a_data, prev_data);
            end
            if (a_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra_beat: got %0h expected no beat", a_data);
                end else begin
                    chk("sb_data", a_data, exp_q[0].d);
                    chk("sb_last", a_last, exp_q[0].last);
                    if (a_clr) discard_word();
                    else if (a_ready) void'(exp_q.pop_front());
                end
            end
            prev_hold = a_valid & ~a_ready & ~a_clr;
            prev_data = a_data;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic wait_a(input logic [7:0] d, input string name);
        int n = 0;
        while (!(a_valid && a_data == d) && n < 20) begin
            step();
            smp();
            n++;
        end
        chk(name, {a_valid, a_data}, {1'b1, d});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((a_valid || !a_empty) && n < 40) begin
            step();
            smp();
            n++;
        end
        chk(name, {a_valid, a_empty}, 2'b01);
    endtask

    logic [7:0] t1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] tb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

    initial begin
        int          pops, nbeats, bad;
        int unsigned pop_cyc [2];
        int unsigned first_cyc, last_cyc;
        logic [7:0]  got [8];
        logic [7:0]  last_map;

        rst_ni  = 1'b0;
        a_clr   = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;

        // Reset state, with a word already waiting in the FIFO
        push_a(32'h44332211);
        smp();
        chk("reset_valid", a_valid, 0);
        chk("reset_last", a_last, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_rdena", a_rdena, 0);

        // Latency and LSB-first beat order
        step(); rst_ni = 1'b1; smp();
        chk("lat_rdena", a_rdena, 1);
        chk("lat_valid", a_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(); smp();
            chk("t1_data", {a_valid, a_data}, {1'b1, t1[i]});
            chk("t1_last", a_last, (i == 3));
            chk("t1_rdena", a_rdena, 0);
        end
        step(); smp();
        chk("t1_idle", a_valid, 0);

        // Back-to-back words: no gap, pops four cycles apart
        step(); push_a(32'h44332211); push_a(32'h88776655); smp();
        pops = 0; nbeats = 0; first_cyc = 0; last_cyc = 0; last_map = '0;
        for (int k = 0; k < 12; k++) begin
            if (a_rdena && pops < 2) begin pop_cyc[pops] = cyc; pops++; end
            if (a_valid && nbeats < 8) begin
                if (nbeats == 0) first_cyc = cyc;
                last_cyc          = cyc;
                got[nbeats]       = a_data;
                last_map[nbeats]  = a_last;
                nbeats++;
            end
            step(); smp();
        end
        chk("t2_pops", pops, 2);
        chk("t2_pop_gap", pop_cyc[1] - pop_cyc[0], 4);
        chk("t2_beats", nbeats, 8);
        chk("t2_no_gap", last_cyc - first_cyc, 7);
        chk("t2_last_map", last_map, 8'b1000_1000);
        for (int i = 0; i < 8; i++) chk("t2_data", got[i], t2[i]);

        // Backpressure on beat 0x22
        step(); push_a(32'h44332211); push_a(32'h88776655); smp();
        wait_a(8'h11, "bp_start");
        step(); a_ready = 1'b0; smp();
        for (int i = 0; i < 3; i++) begin
            chk("bp_data", {a_valid, a_data}, {1'b1, 8'h22});
            chk("bp_rdena", a_rdena, 0);
            if (i < 2) begin step(); smp(); end
        end
        step(); a_ready = 1'b1; smp();
        chk("bp_resume_hold", a_data, 8'h22);
        step(); smp();
        chk("bp_resume", a_data, 8'h33);
        wait_idle("bp_drain");

        // Empty FIFO never popped
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(); smp();
            if (a_rdena) bad++;
        end
        chk("empty_no_rdena", bad, 0);

        // Synchronous clear mid-word
        step(); push_a(32'h44332211); push_a(32'hDDCCBBAA); smp();
        wait_a(8'h11, "clr_start");
        step(); smp();
        chk("clr_pre", a_data, 8'h22);
        step(); a_clr = 1'b1; a_ready = 1'b0; smp();
        chk("clr_rdena", a_rdena, 0);
        step(); a_clr = 1'b0; a_ready = 1'b1; smp();
        chk("clr_valid", a_valid, 0);
        chk("clr_reload", a_rdena, 1);
        step(); smp();
        chk("clr_next", {a_valid, a_data}, {1'b1, 8'hAA});
        wait_idle("clr_drain");

        // Clear gates the pop even when idle with data waiting
        step(); push_a(32'h0D0C0B0A); a_clr = 1'b1; smp();
        chk("clr_gate_rdena", a_rdena, 0);
        step(); a_clr = 1'b0; smp();
        chk("clr_gate_release", a_rdena, 1);
        wait_idle("clr_gate_drain");

        // Asynchronous reset during beat 0x33
        step(); push_a(32'h44332211); push_a(32'h88776655); smp();
        wait_a(8'h33, "rst_start");
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_last", a_last, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rdena", a_rdena, 0);
        discard_word();
        step(); rst_ni = 1'b1; smp();
        chk("rst_reload", a_rdena, 1);
        step(); smp();
        chk("rst_next", {a_valid, a_data}, {1'b1, 8'h55});
        wait_idle("rst_drain");

        // MSB_FIRST instance
        step(); b_mem[b_wp] = 32'h44332211; b_wp++; smp();
        for (int n = 0; n < 5 && !b_valid; n++) begin step(); smp(); end
        for (int i = 0; i < 4; i++) begin
            chk("msb_data", {b_valid, b_data}, {1'b1, tb[i]});
            chk("msb_last", b_last, (i == 3));
            step(); smp();
        end
        chk("msb_idle", b_valid, 0);

        // RATIO=1 instance: pop every cycle, every beat last
        step();
        for (int i = 1; i <= 3; i++) begin c_mem[c_wp] = i; c_wp++; end
        smp();
        chk("r1_rdena0", c_rdena, 1);
        chk("r1_valid0", c_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            chk("r1_data", {c_valid, c_data[30:0]}, {1'b1, 31'(i + 1)});
            chk("r1_last", c_last, 1);
            chk("r1_rdena", c_rdena, (i < 2));
        end
        step(); smp();
        chk("r1_idle", c_valid, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
